// File: rtl/mathv_cnt_pkg.sv
// Shared definitions for the mathV counter-observer stages: the snapshot
// entry format and the helper that sizes fill-level ports.
package mathv_cnt_pkg;

    localparam int CNT_WIDTH = 8;

    typedef struct packed {
        logic                 wrap;
        logic [CNT_WIDTH-1:0] data;
    } snapshot_t;

    // Width needed to hold a fill level of 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO over registered storage.
// The caller qualifies push_i (not full, or popping in the same cycle) and
// pop_i (not empty); full/empty come from the level counter, not pointers.
// When the FIFO drains, head_o keeps showing the last entry that was popped.
module sync_fifo
    import mathv_cnt_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  T                          data_i,
    input  logic                      pop_i,
    output T                          head_o,
    output logic [lvl_w(DEPTH)-1:0]   level_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    T              mem_q [DEPTH];
    T              last_q;
    T              last_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    // Entry storage needs no reset: nothing is visible until level_q says so.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Next pointer/level values; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        level_d  = level_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state register with asynchronous flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
            level_q  <= level_d;
        end
    end

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/count_snapshot_fifo.sv
// Observes the free-running counter, captures {wrap-tag, count} snapshots on
// each sample pulse into a small FIFO, and drains them over valid/ready.
// Also reports the fill level and a sticky overflow flag for dropped samples.
module count_snapshot_fifo
    import mathv_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          count_in,
    input  logic                      count_en,
    input  logic                      sample,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_wrap,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      overflow,
    input  logic                      clear_ovf
);

    logic [WIDTH-1:0] prev_count_q;
    logic             count_en_q;
    logic             wrap_pending_q;
    logic             wrap_pending_d;
    logic             overflow_q;
    logic             overflow_d;

    logic             wrap_now;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    snapshot_t        push_entry;
    snapshot_t        head;

    // A wrap is the enabled step from all-ones back to zero; the enable is
    // delayed a cycle because the counter's value lags its enable by one edge.
    assign wrap_now = count_en_q && (prev_count_q == '1) && (count_in == '0);

    assign pop     = out_valid && out_ready;
    assign push_ok = sample && (!fifo_full || pop);
    assign drop    = sample && fifo_full && !pop;

    assign push_entry.wrap = wrap_pending_q | wrap_now;
    assign push_entry.data = count_in;

    // Wrap tag bookkeeping and sticky overflow; a drop keeps the pending tag
    // for the next accepted entry and beats a simultaneous clear.
    always_comb begin
        wrap_pending_d = wrap_pending_q;
        overflow_d     = overflow_q;
        if (push_ok) begin
            wrap_pending_d = 1'b0;
        end else if (wrap_now) begin
            wrap_pending_d = 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Observer state register with asynchronous flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_count_q   <= '0;
            count_en_q     <= 1'b0;
            wrap_pending_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            prev_count_q   <= count_in;
            count_en_q     <= count_en;
            wrap_pending_q <= wrap_pending_d;
            overflow_q     <= overflow_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (snapshot_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_ok),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head.data;
    assign out_wrap  = head.wrap;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Bench for count_snapshot_fifo: directed scenarios followed by random
// traffic, all checked against a queue-based model of the snapshot FIFO.
module tb_count_snapshot_fifo;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic [7:0]    countIn;
    logic          countEn;
    logic          sample;
    logic [7:0]    outData;
    logic          outWrap;
    logic          outValid;
    logic          outReady;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clearOvf;

    // Model: each entry is {wrap, data}
    logic [8:0]    modelQ[$];
    logic [8:0]    modelLast;
    logic          modelOvf;
    logic          modelPend;
    logic          modelEnD;
    logic [7:0]    modelPrev;
    logic [7:0]    cntReg;

    int            total;
    int            bad;
    int            validCycles;

    count_snapshot_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (countIn),
        .count_en  (countEn),
        .sample    (sample),
        .out_data  (outData),
        .out_wrap  (outWrap),
        .out_valid (outValid),
        .out_ready (outReady),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clearOvf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelLast = '0;
        modelOvf  = 1'b0;
        modelPend = 1'b0;
        modelEnD  = 1'b0;
        modelPrev = '0;
    endtask

    task automatic compareAll();
        logic [8:0] expHead;
        expHead = (modelQ.size() != 0) ? modelQ[0] : modelLast;
        checkOutput("out_valid", outValid, modelQ.size() != 0);
        checkOutput("out_data", outData, expHead[7:0]);
        checkOutput("out_wrap", outWrap, expHead[8]);
        checkOutput("level", level, modelQ.size());
        checkOutput("overflow", overflow, modelOvf);
    endtask

    // One clock: drive at negedge, advance the model, compare after the edge.
    task automatic applyStimulus(input logic en, input logic smp, input logic rdy, input logic clr);
        logic doPop;
        logic wrapNow;
        logic isFull;
        logic pushOk;
        @(negedge clk);
        countIn  = cntReg;
        countEn  = en;
        sample   = smp;
        outReady = rdy;
        clearOvf = clr;
        #1;
        checkOutput("valid_pre_edge", outValid, modelQ.size() != 0);
        doPop   = (modelQ.size() != 0) && rdy;
        wrapNow = modelEnD && (modelPrev == 8'hFF) && (cntReg == 8'h00);
        isFull  = (modelQ.size() == DEPTH);
        pushOk  = smp && (!isFull || doPop);
        if (doPop) begin
            modelLast = modelQ.pop_front();
        end
        if (pushOk) begin
            modelQ.push_back({modelPend | wrapNow, cntReg});
            modelPend = 1'b0;
        end else if (wrapNow) begin
            modelPend = 1'b1;
        end
        if (smp && !pushOk) begin
            modelOvf = 1'b1;
        end else if (clr) begin
            modelOvf = 1'b0;
        end
        modelPrev = cntReg;
        modelEnD  = en;
        cntReg    = cntReg + 8'(en);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        countIn  = '0;
        countEn  = 1'b0;
        sample   = 1'b0;
        outReady = 1'b0;
        clearOvf = 1'b0;
        cntReg   = '0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", outValid, 0);
        checkOutput("reset_data", outData, 0);
        checkOutput("reset_wrap", outWrap, 0);
        checkOutput("reset_level", level, 0);
        checkOutput("reset_ovf", overflow, 0);
        reset = 1'b1;

        // Basic capture on a 0..20 ramp
        cntReg      = 8'd0;
        validCycles = 0;
        for (int c = 0; c <= 20; c++) begin
            applyStimulus(1'b1, (c == 5) || (c == 9), 1'b1, 1'b0);
            if (outValid) validCycles++;
            if (c == 5) begin
                checkOutput("basic_beat5", {outWrap, outData}, 9'd5);
            end
            if (c == 9) begin
                checkOutput("basic_beat9", {outWrap, outData}, 9'd9);
            end
        end
        checkOutput("basic_valid_cycles", validCycles, 2);
        checkOutput("basic_level_end", level, 0);

        // Wrap tag across 255 -> 0
        cntReg = 8'd254;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, (c == 3) || (c == 5), 1'b1, 1'b0);
            if (c == 3) checkOutput("wrap_tagged", {outWrap, outData}, {1'b1, 8'd1});
            if (c == 5) checkOutput("wrap_untagged", {outWrap, outData}, {1'b0, 8'd3});
        end

        // Backpressure until full, one dropped sample
        cntReg = 8'd10;
        for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_level", level, 4);
        checkOutput("bp_ovf", overflow, 1);
        checkOutput("bp_head", outData, 10);
        for (int c = 0; c < 4; c++) begin
            checkOutput("bp_drain_order", outData, 10 + c);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("bp_drained", level, 0);

        // Full with simultaneous pop: no overflow, level holds
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("fullpop_level", level, 4);
        checkOutput("fullpop_ovf", overflow, 0);

        // Drop and clear in the same cycle: set wins
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("race_ovf_set", overflow, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("race_ovf_clear", overflow, 0);

        // Async reset while holding 3 entries with overflow set
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_reset_level", level, 3);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_valid", outValid, 0);
        checkOutput("async_level", level, 0);
        checkOutput("async_ovf", overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset();
        cntReg = 8'd7;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_entry", {outValid, outWrap, outData}, {1'b1, 1'b0, 8'd7});

        // Random traffic around the wrap point
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(15) == 0) begin
                cntReg = ($urandom_range(1) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            end
            applyStimulus($urandom_range(3) != 0, $urandom_range(9) < 4,
                          $urandom_range(1) == 0, $urandom_range(9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_snapshot_fifo.md
Name: count_snapshot_fifo

Overview:
- Downstream consumer of the free-running up-counter; observes the counter's `count` output and its `enable` strobe.
- On each `sample` pulse, captures the current count plus a "wrapped since last capture" tag into a small FIFO.
- Drains the FIFO through a valid/ready interface to the next math/stats stage.
- Reports fill level and a sticky overflow flag.

Parameters:
- WIDTH, 8, width of the observed count; must equal the counter's WIDTH.
- DEPTH, 4, FIFO entries; power of two, 2 to 16.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; assert asynchronously, deassert synchronous to clk externally.
- count_in  in  WIDTH  counter value, sampled each rising edge.
- count_en  in  1  the counter's enable; qualifies wrap detection.
- sample  in  1  capture request, one entry per cycle high.
- out_data  out  WIDTH  head-entry count value.
- out_wrap  out  1  head-entry wrap tag.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts head when out_valid is high.
- level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky; set when a sample is dropped.
- clear_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0), asynchronous:
  - out_valid=0, out_data=0, out_wrap=0, level=0, overflow=0.
  - Internal prev_count=0, wrap_pending=0, read/write pointers=0.
- prev_count <= count_in every cycle.
- Wrap event, combinational:
  - wrap_now = count_en_d && prev_count == all-ones && count_in == 0.
  - count_en_d is count_en registered one cycle, matching the counter's one-cycle update latency.
- wrap_pending:
  - Set on wrap_now.
  - Cleared on an accepted push, unless wrap_now is also true that cycle; in that case the wrap is attributed to the pushed entry and the flag stays clear.
- Pushed entry fields: {wrap = wrap_pending | wrap_now, data = count_in}.
- push_ok = sample && (level < DEPTH || pop), where pop = out_valid && out_ready.
  - Push while full is allowed only when a pop happens in the same cycle.
- Dropped sample (sample && full && !pop):
  - No write; overflow <= 1.
  - wrap_pending is retained, so the next accepted entry still carries the tag.
- overflow clear: clear_ovf clears it; if a drop occurs in the same cycle, set wins.
- Output is first-word-fall-through from registered storage:
  - A push at edge N makes out_valid=1 after edge N when the FIFO was empty.
  - No same-cycle combinational bypass from sample to out_valid.
- Pop advances the head; out_data/out_wrap show the next entry immediately after the edge, or hold their last value with out_valid=0 when the FIFO goes empty.
- level update each edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_valid stays high until accepted; out_data/out_wrap must not change while out_valid=1 and out_ready=0.
- Pointer wrap: modulo DEPTH; full/empty derived from level, never from pointer equality alone.
- Reset mid-operation flushes all entries immediately; the consumer must treat out_valid as low during reset.
- count_in X/unknown values are not filtered; the bench drives known values only.

Decomposition:
- Shared package mathv_cnt_pkg holds:
  - snapshot_t packed struct {logic wrap; logic [WIDTH-1:0] data}, with WIDTH taken from the package localparam CNT_WIDTH=8.
  - A function lvl_w(depth) returning $clog2(depth)+1.
- One natural sub-module, sync_fifo: parameterised DEPTH and entry type; push/pop/level/head ports; also reusable by other mathV stages.
- Top level holds wrap detection, overflow logic, and handshake glue.

Test Plan:
- Basic capture: count_in ramps 0..20 with count_en=1; pulse sample at count=5 and count=9; out_ready=1 -> two beats {0,5} then {0,9}; out_valid high for exactly one cycle each; level returns to 0.
- Wrap tag: count_in 254, 255, 0, 1 with count_en=1; sample at count=1 -> entry {wrap=1, data=1}. Next sample at 3 -> {wrap=0, data=3}.
- Backpressure/full: out_ready=0, DEPTH=4, samples at counts 10, 11, 12, 13, 14 -> level=4, overflow=1, out_data stays 10. Then out_ready=1 -> drains 10, 11, 12, 13 in order, one per cycle; 14 never appears.
- Full with simultaneous pop: FIFO full, sample and out_ready both high in the same cycle -> no overflow; level stays 4; new value is appended at the tail.
- Overflow clear race: clear_ovf=1 in the same cycle as a dropped sample -> overflow remains 1. clear_ovf alone next cycle -> overflow=0.
- Async reset mid-drain: hold 3 entries, drop reset low between edges -> out_valid, level and overflow go to 0 immediately without a clock edge. After release, first sample at count=7 -> {0,7}.
